// File: rtl/piso_serializer.sv
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word
//               over valid/ready and shifts it out MSB-first, one bit per clk,
//               with first/last frame strobes for downstream re-framing.
//               Optional macro PISO_PARITY_EN appends an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int                 CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   c_LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic w_final;
    logic w_accept;

`ifdef PISO_PARITY_EN
    assign w_final = (state_q == ST_PAR);
`else
    assign w_final = (state_q == ST_SHIFT) && (cnt_q == c_LAST_CNT);
`endif

    // Ready when idle or on the last bit of the frame, so frames can abut.
    assign in_ready  = rst_n & ((state_q == ST_IDLE) | w_final);
    assign w_accept  = in_valid & in_ready;

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign busy      = ser_valid_q;

    // Next-state and next-output logic; idle outputs unless a frame bit is due.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d       = par_q;
`endif
        if (w_accept) begin
            // MSB goes straight to the output register; the rest queue up.
            state_d     = ST_SHIFT;
            cnt_d       = '0;
            shreg_d     = {in_data[WIDTH-2:0], 1'b0};
            ser_out_d   = in_data[WIDTH-1];
            ser_valid_d = 1'b1;
            ser_first_d = 1'b1;
`ifdef PISO_PARITY_EN
            par_d       = ^in_data;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q != c_LAST_CNT) begin
                        cnt_d       = cnt_q + 1'b1;
                        shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                        ser_out_d   = shreg_q[WIDTH-1];
                        ser_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
                        ser_last_d  = 1'b0;
`else
                        ser_last_d  = (cnt_q == c_LAST_CNT - 1'b1);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d     = ST_PAR;
                        ser_out_d   = par_q;
                        ser_valid_d = 1'b1;
                        ser_last_d  = 1'b1;
`else
                        state_d     = ST_IDLE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PAR: begin
                    state_d = ST_IDLE;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module      : tb_piso_serializer
// Description : Scoreboard bench for piso_serializer. Accepted words are
//               expanded into the expected serial bit stream and queued; a
//               negedge monitor pops one entry per cycle and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

    localparam int   W        = 8;
    localparam logic IDLE_LVL = 1'b1;
`ifdef PISO_PARITY_EN
    localparam bit   PAR_EN   = 1'b1;
`else
    localparam bit   PAR_EN   = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } item_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_first;
    logic         ser_last;
    logic         busy;

    item_t exp_q[$];
    int    n_cmp;
    int    n_bad;
    bit    mon_en;

    piso_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_LVL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .ser_first(ser_first),
        .ser_last (ser_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expand one word into its serial frame: MSB first, optional parity tail.
    task automatic push_frame(input logic [W-1:0] d);
        item_t it;
        for (int i = W - 1; i >= 0; i--) begin
            it.b     = d[i];
            it.first = (i == W - 1);
            it.last  = (i == 0) && !PAR_EN;
            exp_q.push_back(it);
        end
        if (PAR_EN) begin
            it.b     = ^d;
            it.first = 1'b0;
            it.last  = 1'b1;
            exp_q.push_back(it);
        end
    endtask

    // Monitor: one expected entry per cycle, or idle when nothing is queued.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [4:0] act, expv;
            item_t      it;
            act = {ser_valid, ser_out, ser_first, ser_last, busy};
            if (exp_q.size() == 0) begin
                expv = {1'b0, IDLE_LVL, 1'b0, 1'b0, 1'b0};
            end else begin
                it   = exp_q.pop_front();
                expv = {1'b1, it.b, it.first, it.last, 1'b1};
            end
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL serial_out t=%0t {valid,out,first,last,busy} actual=%b required=%b",
                         $time, act, expv);
            end
        end
    end

    // One stimulus cycle, driven just after negedge. The next frame may be
    // accepted only once no future bits remain queued (idle or final bit).
    task automatic cyc(input logic rst, input logic v, input logic [W-1:0] d, output bit acc);
        bit model_rdy;
        rst_n    = rst;
        in_valid = v;
        in_data  = d;
        if (!rst) exp_q.delete();
        #1;
        model_rdy = rst && (exp_q.size() == 0);
        n_cmp++;
        if (in_ready !== model_rdy) begin
            n_bad++;
            $display("FAIL in_ready t=%0t actual=%b required=%b", $time, in_ready, model_rdy);
        end
        acc = v && model_rdy;
        if (acc) push_frame(d);
        @(negedge clk);
        #1;
    endtask

    // Offer a word until accepted (bounded), then drop valid.
    task automatic send(input logic [W-1:0] d);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 4 * W) begin
            cyc(1'b1, 1'b1, d, acc);
            guard++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout word=%h actual=not_accepted required=accepted", d);
        end
    endtask

    initial begin
        bit acc;
        n_cmp    = 0;
        n_bad    = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;

        // Reset held with valid asserted: never ready, outputs idle.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hFF, acc);
        cyc(1'b1, 1'b0, 8'h00, acc);

        // Single A5 frame followed by idle.
        send(8'hA5);
        for (int i = 0; i < W + 3; i++) cyc(1'b1, 1'b0, 8'h00, acc);

        // Back-to-back A5 then 3C.
        send(8'hA5);
        send(8'h3C);
        for (int i = 0; i < W + 3; i++) cyc(1'b1, 1'b0, 8'h00, acc);

        // FF offered mid-frame must be ignored until the final bit.
        send(8'hA5);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'hFF, acc);
        for (int i = 0; i < W + 3; i++) cyc(1'b1, 1'b0, 8'h00, acc);

        // Reset asserted on the 4th bit of a frame, then immediate new word.
        send(8'hA5);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 8'h00, acc);
        cyc(1'b0, 1'b0, 8'h00, acc);
        cyc(1'b1, 1'b1, 8'h07, acc);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_after_reset actual=0 required=1");
        end
        for (int i = 0; i < W + 3; i++) cyc(1'b1, 1'b0, 8'h00, acc);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 50) != 0, ($urandom % 3) != 0, W'($urandom), acc);
        end
        for (int i = 0; i < W + 4; i++) cyc(1'b1, 1'b0, 8'h00, acc);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
